// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Scoreboard-based sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
//   Tracks destination registers in flight after ID and stalls fetch/decode
//   on read-after-write hazards. It also inserts bubbles into ID/EX, flushes
//   the fetched word on taken branches, and drains the pipe before halting.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : write-through regfile, so the WB entry is not compared
//                 (max stall 2 cycles)
//     undefined : every tracked entry is compared (max stall 3 cycles)
//
// Ports
//   clk          system clock
//   rst_         asynchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_r1_addr   ID source register 1
//   id_r2_addr   ID source register 2
//   id_use_r1    instruction reads r1
//   id_use_r2    instruction reads r2
//   id_rw_       instruction writes the register file (active low)
//   id_waddr     ID destination register
//   id_halt      ID instruction is halt
//   br_taken     branch/jump resolved taken in ID
//   load_instr   pc and instr_reg advance this cycle
//   bubble       pipe_id_ex loads a NOP
//   flush        instr_reg loads a NOP instead of the fetched word
//   halt         pipeline drained, sticky until reset
//   stall_cnt    saturating count of hazard-stall cycles
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_BITS = 5,
  parameter int TRACK_STAGES  = 3,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     id_valid,
  input  logic [REG_ADDR_BITS-1:0] id_r1_addr,
  input  logic [REG_ADDR_BITS-1:0] id_r2_addr,
  input  logic                     id_use_r1,
  input  logic                     id_use_r2,
  input  logic                     id_rw_,
  input  logic [REG_ADDR_BITS-1:0] id_waddr,
  input  logic                     id_halt,
  input  logic                     br_taken,
  output logic                     load_instr,
  output logic                     bubble,
  output logic                     flush,
  output logic                     halt,
  output logic [CNT_BITS-1:0]      stall_cnt
);

  localparam int unsigned NT = TRACK_STAGES;
`ifdef WB_BYPASS_EN
  // WB writes through to the regfile, so the oldest entry never blocks a read.
  localparam int unsigned N_CMP = TRACK_STAGES - 1;
`else
  localparam int unsigned N_CMP = TRACK_STAGES;
`endif
  localparam int DW = $clog2(TRACK_STAGES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t                   state, state_nxt;
  logic [DW-1:0]            drain_cnt, drain_cnt_nxt;
  logic [NT-1:0]            sb_valid;
  logic [REG_ADDR_BITS-1:0] sb_waddr [NT];
  logic                     r1_hit, r2_hit, hazard, issue, sb_load, stall;

  always_comb begin
    r1_hit = 1'b0;
    r2_hit = 1'b0;
    for (int unsigned i = 0; i < N_CMP; i++) begin
      if (sb_valid[i] && (sb_waddr[i] == id_r1_addr)) r1_hit = 1'b1;
      if (sb_valid[i] && (sb_waddr[i] == id_r2_addr)) r2_hit = 1'b1;
    end
    hazard = id_valid &&
             ((id_use_r1 && (id_r1_addr != '0) && r1_hit) ||
              (id_use_r2 && (id_r2_addr != '0) && r2_hit));
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    load_instr    = 1'b1;
    bubble        = 1'b0;
    flush         = 1'b0;
    halt          = 1'b0;
    issue         = 1'b0;
    stall         = 1'b0;
    case (state)
      S_RUN: begin
        if (hazard) begin
          // Stall beats both branch flush and halt; they re-evaluate later.
          load_instr = 1'b0;
          bubble     = 1'b1;
          stall      = 1'b1;
        end else begin
          issue = 1'b1;
          flush = br_taken;
          if (id_valid && id_halt) begin
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = DW'(TRACK_STAGES);
          end
        end
      end
      S_DRAIN: begin
        load_instr    = 1'b0;
        bubble        = 1'b1;
        drain_cnt_nxt = drain_cnt - 1'b1;
        if (drain_cnt_nxt == '0) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        load_instr = 1'b0;
        bubble     = 1'b1;
        halt       = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
    // Writes to r0 are never tracked, so r0 can never cause a hazard.
    sb_load = issue && id_valid && !id_rw_ && (id_waddr != '0);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      sb_valid  <= '0;
      for (int unsigned i = 0; i < NT; i++) sb_waddr[i] <= '0;
      stall_cnt <= '0;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_cnt_nxt;
      sb_valid[0] <= sb_load;
      sb_waddr[0] <= id_waddr;
      for (int unsigned i = 1; i < NT; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_waddr[i] <= sb_waddr[i-1];
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef WB_BYPASS_EN
  localparam int NW = 2;
`else
  localparam int NW = 3;
`endif
  localparam int STALL_MAX = NW;
  localparam int DRAIN_LEN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_;
  logic       id_valid, id_use_r1, id_use_r2, id_rw_, id_halt, br_taken;
  logic [4:0] id_r1_addr, id_r2_addr, id_waddr;
  logic       load_instr, bubble, flush, halt;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(.REG_ADDR_BITS(5), .TRACK_STAGES(3), .CNT_BITS(16)) dut (
    .clk(clk), .rst_(rst_), .id_valid(id_valid),
    .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .id_rw_(id_rw_),
    .id_waddr(id_waddr), .id_halt(id_halt), .br_taken(br_taken),
    .load_instr(load_instr), .bubble(bubble), .flush(flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  // Reference model: hist[k] is the register written by the instruction
  // issued k+1 cycles ago (0 when none, which also covers writes to r0).
  int hist [3];
  int m_st;      // 0 running, 1 draining, 2 halted
  int m_drain;
  int m_stall;
  logic e_hz, e_load, e_bub, e_fl, e_halt;
  logic [15:0] e_stall;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic in_window(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int k = 0; k < NW; k++) if (hist[k] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    e_hz    = id_valid && ((id_use_r1 && in_window(id_r1_addr)) ||
                           (id_use_r2 && in_window(id_r2_addr)));
    e_stall = 16'(m_stall);
    e_halt  = (m_st == 2);
    e_fl    = 1'b0;
    if (m_st != 0 || e_hz) begin
      e_load = 1'b0; e_bub = 1'b1;
    end else begin
      e_load = 1'b1; e_bub = 1'b0; e_fl = br_taken;
    end
  endfunction

  function automatic void model_tick();
    int dest = 0;
    if (m_st == 0 && !e_hz) begin
      if (id_valid && !id_rw_) dest = int'(id_waddr);
      if (id_valid && id_halt) begin m_st = 1; m_drain = DRAIN_LEN; end
    end else if (m_st == 0) begin
      if (m_stall < 65535) m_stall++;
    end else if (m_st == 1) begin
      m_drain--;
      if (m_drain == 0) m_st = 2;
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = dest;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) hist[k] = 0;
    m_st = 0; m_drain = 0; m_stall = 0;
  endfunction

  task automatic set_instr(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic u1, input logic u2, input logic rw,
                           input logic [4:0] wa, input logic hl, input logic br);
    id_valid = v; id_r1_addr = r1; id_r2_addr = r2; id_use_r1 = u1; id_use_r2 = u2;
    id_rw_ = rw; id_waddr = wa; id_halt = hl; br_taken = br;
  endtask

  task automatic cyc();
    model_eval();
    @(posedge clk);
    if (rst_) model_tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
    rst_ = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, flush, halt} !== 4'b1000) begin
      n_err++; $display("FAIL reset_ctl got %b want %b", {load_instr, bubble, flush, halt}, 4'b1000);
    end
    n_vec++;
    if (stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt);
    end
    cyc();
  endtask

  task automatic test_raw_stall();
    int nb = 0;
    do_reset();
    set_instr(1, 0, 0, 0, 0, 0, 5'd3, 0, 0);
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, flush, halt} !== {e_load, e_bub, e_fl, e_halt}) begin
      n_err++; $display("FAIL raw_issue got %b want %b", {load_instr, bubble, flush, halt}, {e_load, e_bub, e_fl, e_halt});
    end
    cyc();
    set_instr(1, 5'd3, 0, 1, 0, 1, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      #1; model_eval();
      n_vec++;
      if ({load_instr, bubble, flush, halt} !== {e_load, e_bub, e_fl, e_halt}) begin
        n_err++; $display("FAIL raw_ctl c%0d got %b want %b", c, {load_instr, bubble, flush, halt}, {e_load, e_bub, e_fl, e_halt});
      end
      if (bubble) nb++;
      if (e_load) break;
      cyc();
    end
    n_vec++;
    if (nb != STALL_MAX) begin
      n_err++; $display("FAIL raw_len got %0d want %0d", nb, STALL_MAX);
    end
    n_vec++;
    if (stall_cnt !== 16'(STALL_MAX)) begin
      n_err++; $display("FAIL raw_stall_cnt got %0d want %0d", stall_cnt, STALL_MAX);
    end
    cyc();
  endtask

  task automatic test_r0();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    cyc();
    for (int c = 0; c < 4; c++) begin
      set_instr(1, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
      #1; model_eval();
      n_vec++;
      if ({load_instr, bubble} !== 2'b10) begin
        n_err++; $display("FAIL r0_ctl c%0d got %b want 10", c, {load_instr, bubble});
      end
      n_vec++;
      if (stall_cnt !== 16'd0) begin
        n_err++; $display("FAIL r0_stall got %0d want 0", stall_cnt);
      end
      cyc();
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_instr(1, 5'd4, 0, 1, 0, 1, 0, 0, 1);
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, flush} !== 3'b101) begin
      n_err++; $display("FAIL br_ctl got %b want 101", {load_instr, bubble, flush});
    end
    cyc();
    set_instr(1, 5'd4, 0, 1, 0, 1, 0, 0, 0);
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, flush} !== 3'b100) begin
      n_err++; $display("FAIL br_next got %b want 100", {load_instr, bubble, flush});
    end
    cyc();
  endtask

  task automatic test_branch_hazard();
    int nfl = 0;
    do_reset();
    set_instr(1, 0, 0, 0, 0, 0, 5'd5, 0, 0);
    cyc();
    set_instr(1, 5'd1, 5'd5, 0, 1, 1, 0, 0, 1);
    for (int c = 0; c < 8; c++) begin
      #1; model_eval();
      n_vec++;
      if ({load_instr, bubble, flush, halt} !== {e_load, e_bub, e_fl, e_halt}) begin
        n_err++; $display("FAIL brhz_ctl c%0d got %b want %b", c, {load_instr, bubble, flush, halt}, {e_load, e_bub, e_fl, e_halt});
      end
      if (flush) nfl++;
      if (e_load) break;
      cyc();
    end
    n_vec++;
    if (nfl != 1 || flush !== 1'b1) begin
      n_err++; $display("FAIL brhz_flush got count %0d last %b want 1 1", nfl, flush);
    end
    cyc();
  endtask

  task automatic test_halt();
    int nb = 0;
    do_reset();
    set_instr(1, 0, 0, 0, 0, 1, 0, 1, 0);
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, halt} !== 3'b100) begin
      n_err++; $display("FAIL halt_issue got %b want 100", {load_instr, bubble, halt});
    end
    cyc();
    for (int c = 0; c < 7; c++) begin
      set_instr(1, 5'd2, 0, 1, 0, 0, 5'd6, 0, 1);
      #1; model_eval();
      n_vec++;
      if ({load_instr, bubble, flush, halt} !== {e_load, e_bub, e_fl, e_halt}) begin
        n_err++; $display("FAIL halt_ctl c%0d got %b want %b", c, {load_instr, bubble, flush, halt}, {e_load, e_bub, e_fl, e_halt});
      end
      if (bubble && !halt) nb++;
      cyc();
    end
    n_vec++;
    if (nb != DRAIN_LEN || halt !== 1'b1) begin
      n_err++; $display("FAIL halt_drain got %0d halt %b want %0d 1", nb, halt, DRAIN_LEN);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 0, 5'd7, 0, 0);
    cyc();
    set_instr(1, 5'd7, 0, 1, 0, 1, 0, 0, 1);
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, flush} !== {e_load, e_bub, e_fl}) begin
      n_err++; $display("FAIL rstmid_pre got %b want %b", {load_instr, bubble, flush}, {e_load, e_bub, e_fl});
    end
    rst_ = 1'b0; #1; model_reset(); model_eval();
    n_vec++;
    if ({load_instr, bubble, flush, halt} !== 4'b1010 || stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL rstmid_stall got %b cnt %0d want 1010 cnt 0", {load_instr, bubble, flush, halt}, stall_cnt);
    end
    cyc();
    rst_ = 1'b1; #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, flush, halt} !== {e_load, e_bub, e_fl, e_halt}) begin
      n_err++; $display("FAIL rstmid_after got %b want %b", {load_instr, bubble, flush, halt}, {e_load, e_bub, e_fl, e_halt});
    end
    cyc();
    set_instr(1, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc();
    set_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1; model_eval();
    n_vec++;
    if ({load_instr, bubble, halt} !== 3'b010) begin
      n_err++; $display("FAIL rstdrain_pre got %b want 010", {load_instr, bubble, halt});
    end
    rst_ = 1'b0; #1; model_reset(); model_eval();
    n_vec++;
    if ({load_instr, bubble, flush, halt} !== 4'b1000 || stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL rstdrain got %b cnt %0d want 1000 cnt 0", {load_instr, bubble, flush, halt}, stall_cnt);
    end
    cyc();
    rst_ = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1; model_eval();
      n_vec++;
      if ({load_instr, bubble, halt} !== 3'b100) begin
        n_err++; $display("FAIL rstdrain_after c%0d got %b want 100", c, {load_instr, bubble, halt});
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic need_new = 1'b1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (need_new) begin
        set_instr(($urandom_range(9) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
                  1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(7)),
                  1'b0, ($urandom_range(6) == 0));
      end
      #1; model_eval();
      n_vec++;
      if ({load_instr, bubble, flush, halt} !== {e_load, e_bub, e_fl, e_halt}) begin
        n_err++; $display("FAIL rand_ctl c%0d got %b want %b", c, {load_instr, bubble, flush, halt}, {e_load, e_bub, e_fl, e_halt});
      end
      n_vec++;
      if (stall_cnt !== e_stall) begin
        n_err++; $display("FAIL rand_stall c%0d got %0d want %0d", c, stall_cnt, e_stall);
      end
      need_new = e_load;
      cyc();
    end
  endtask

  initial begin
    set_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
    rst_ = 1'b0;
    model_reset();
    test_reset();
    test_raw_stall();
    test_r0();
    test_branch();
    test_branch_hazard();
    test_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
